spart_core: RTL
===============

// Module: spart_core
// PURPOSE
//  Special-purpose async receiver/transmitter sitting directly below the bus
//  driver: decodes iocs/iorw/ioaddr/databus accesses, holds the 16-bit baud
//  divisor, generates a 16x oversample tick, serialises TX bytes (8N1, LSB
//  first) onto txd and deserialises rxd into a receive buffer, flagging tbr/rda.
// PARAMETERS
//  DEFAULT_DIV     16'd324  divisor after reset; tick period = DEFAULT_DIV+1 clks
//  RX_SYNC_STAGES  2        flops in rxd metastability synchroniser (>=2)
// PORTS
//  clk      in    1  system clock, all logic on posedge
//  rst      in    1  reset, asynchronous, active-low
//  iocs     in    1  chip select; access valid only when 1
//  iorw     in    1  1 = read (core drives databus), 0 = write
//  ioaddr   in    2  00 data, 01 status/ctrl, 10 divisor low, 11 divisor high
//  databus  inout 8  bidirectional data bus
//  rda      out   1  receive data available
//  tbr      out   1  transmit buffer ready
//  txd      out   1  serial transmit line, idle high
//  rxd      in    1  serial receive line, asynchronous
// BEHAVIOUR
//  Reset (rst=0): txd=1, tbr=1, rda=0, databus=Z, divisor=DEFAULT_DIV,
//   rx/tx FSMs IDLE, status error bits 0, baud counter loaded with divisor.
//  Bus: databus driven only while iocs&&iorw (combinational), else Z.
//   Read 00 -> rx buffer; rda clears on the clk edge of that access.
//   Read 01 -> {4'b0, ovr, ferr, tbr, rda}; ovr/ferr clear on that edge.
//   Read 10/11 -> divisor[7:0]/[15:8]. Write 10/11 -> that half updated and
//   baud counter reloaded same edge (tick restarts from new value).
//   Write 00 with tbr=1 -> byte latched, tbr=0 next cycle; with tbr=0 ignored.
//  Baud: 16-bit down-counter; 1-clk tick when count==0, then reload divisor.
//  TX FSM IDLE->START->DATA(8 bits)->STOP->IDLE; each bit lasts 16 ticks.
//   Leaves IDLE on first tick after write; tbr=1 again on the clk after STOP
//   ends. txd registered, glitch-free.
//  RX FSM on synchronised rxd: IDLE -> START on falling edge; after 8 ticks
//   recheck: low -> DATA, high -> IDLE (glitch rejected). DATA samples every
//   16 ticks (bit centre), LSB first, 3-bit counter wraps 7->0 into STOP.
//   STOP sample high -> buffer loaded, rda=1 next clk; low -> byte dropped,
//   ferr=1. New byte while rda=1 -> buffer overwritten, ovr=1, rda stays 1.
//  Simultaneous read-00 and new-byte completion same edge: new byte wins,
//   rda stays 1, ovr not set.
//  Reset mid-frame: both FSMs abort to IDLE immediately, txd=1 asynchronously.
// CONFIGURATION
//  SPART_LOOPBACK_EN defined: status/ctrl write (addr 01) bit0 sets loop;
//   when loop=1 RX input is internal TX line and txd held 1; read 01 bit7=loop;
//   loop resets to 0.
//  Undefined: writes to 01 ignored, status bit7 reads 0, RX always from rxd.
// TESTING
//  Reset, read 10/11 -> 8'h44/8'h01; tbr=1, rda=0, txd=1, databus Z.
//  Write 10=8'h03,11=8'h00; write 00=8'hA5 -> txd: 0,1,0,1,0,0,1,0,1,1 each
//   64 clks; tbr=0 during frame, 1 after stop.
//  Drive rxd frame 8'h3C at divisor 3 -> rda=1 after stop centre; read 00
//   = 8'h3C, rda=0 next clk.
//  rxd low pulse 4 ticks -> no rda; frame with stop=0 -> rda=0, status ferr=1.
//  Two frames 8'h11,8'h22 without read -> read 00 = 8'h22, status ovr=1,
//   cleared after status read.
//  SPART_LOOPBACK_EN: write 01=8'h01, write 00=8'h5A -> txd stays 1,
//   rda=1 and read 00 = 8'h5A; rst pulse mid-frame -> txd=1, tbr=1.

Source files
------------

// File: rtl/spart_core_if.sv
// spart_core_if: processor-side control and flag signals of the SPART
interface spart_core_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;
  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_core.sv
// spart_core: bus-mapped 8N1 UART with 16x baud tick; optional SPART_LOOPBACK_EN routes TX into RX
module spart_core #(
  parameter logic [15:0] DEFAULT_DIV    = 16'd324,
  parameter int          RX_SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  spart_core_if.slave  bus,
  inout  wire  [7:0]   databus,
  output logic         txd,
  input  logic         rxd
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_state, tx_next, rx_state, rx_next;
  logic [15:0] div, cnt;
  logic tick, wr, rd, loop, tbr, rda, ovr, ferr, txd_r, rx_in, rx_prev;
  logic tx_end, tx_done, rx_mid, rx_end, rx_done, rx_bad, tx_load;
  logic [3:0] tx_tc, rx_tc;
  logic [2:0] tx_bit, rx_bit;
  logic [7:0] tx_shift, tx_shift_nx, rx_shift, rx_buf, rd_data, din;
  logic [RX_SYNC_STAGES-1:0] sync;
  assign wr      = bus.iocs && !bus.iorw;
  assign rd      = bus.iocs && bus.iorw;
  assign din     = databus;
  assign tick    = cnt == 16'd0;
  assign tx_load = wr && bus.ioaddr == 2'd0 && tbr;
  assign rx_in   = loop ? txd_r : sync[RX_SYNC_STAGES-1];
  assign txd     = loop ? 1'b1 : txd_r;
  assign bus.tbr = tbr;
  assign bus.rda = rda;
  assign databus = rd ? rd_data : 8'bz;
`ifdef SPART_LOOPBACK_EN
  // loopback control bit, written through the status/ctrl address
  always_ff @(posedge clk or negedge rst)
    if (!rst) loop <= 1'b0;
    else if (wr && bus.ioaddr == 2'd1) loop <= din[0];
`else
  assign loop = 1'b0;
`endif
  // read mux for the processor bus
  always_comb
    rd_data = bus.ioaddr == 2'd0 ? rx_buf :
              bus.ioaddr == 2'd1 ? {loop, 3'b0, ovr, ferr, tbr, rda} :
              bus.ioaddr == 2'd2 ? div[7:0] : div[15:8];
  // divisor register and baud down-counter; a divisor write restarts the tick
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div <= DEFAULT_DIV;
      cnt <= DEFAULT_DIV;
    end else if (wr && bus.ioaddr == 2'd2) begin
      div[7:0] <= din;
      cnt      <= {div[15:8], din};
    end else if (wr && bus.ioaddr == 2'd3) begin
      div[15:8] <= din;
      cnt       <= {din, div[7:0]};
    end else cnt <= tick ? div : cnt - 16'd1;
  // rxd synchroniser and edge history
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync    <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[RX_SYNC_STAGES-2:0], rxd};
      rx_prev <= rx_in;
    end
  // TX next state; a frame only starts on a tick so every bit spans 16 ticks
  always_comb begin
    tx_next     = tx_state;
    tx_end      = tick && tx_tc == 4'd15;
    tx_done     = tx_state == STOP && tx_end;
    tx_shift_nx = (tx_state == DATA && tx_end) ? {1'b0, tx_shift[7:1]} : tx_shift;
    unique case (tx_state)
      IDLE:  if (tick && !tbr) tx_next = START;
      START: if (tx_end) tx_next = DATA;
      DATA:  if (tx_end && tx_bit == 3'd7) tx_next = STOP;
      STOP:  if (tx_end) tx_next = IDLE;
    endcase
  end
  // TX state, counters, shifter and registered line
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_state <= IDLE;
      tx_tc    <= 4'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      txd_r    <= 1'b1;
      tbr      <= 1'b1;
    end else begin
      tx_state <= tx_next;
      if (tick) tx_tc <= tx_state == IDLE ? 4'd0 : tx_tc + 4'd1;
      if (tx_state == DATA && tx_end) tx_bit <= tx_bit + 3'd1;
      tx_shift <= tx_load ? din : tx_shift_nx;
      tbr      <= tx_done ? 1'b1 : tx_load ? 1'b0 : tbr;
      txd_r    <= tx_next == START ? 1'b0 : tx_next == DATA ? tx_shift_nx[0] : 1'b1;
    end
  // RX next state; start bit rechecked at its centre to reject glitches
  always_comb begin
    rx_next = rx_state;
    rx_mid  = tick && rx_tc == 4'd7;
    rx_end  = tick && rx_tc == 4'd15;
    rx_done = rx_state == STOP && rx_end && rx_in;
    rx_bad  = rx_state == STOP && rx_end && !rx_in;
    unique case (rx_state)
      IDLE:  if (rx_prev && !rx_in) rx_next = START;
      START: if (rx_mid) rx_next = rx_in ? IDLE : DATA;
      DATA:  if (rx_end && rx_bit == 3'd7) rx_next = STOP;
      STOP:  if (rx_end) rx_next = IDLE;
    endcase
  end
  // RX state, sampling, receive buffer and status flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_state <= IDLE;
      rx_tc    <= 4'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
      rx_buf   <= 8'd0;
      rda      <= 1'b0;
      ovr      <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rx_tc    <= (rx_state == IDLE || (rx_state == START && rx_mid)) ? 4'd0 :
                  tick ? rx_tc + 4'd1 : rx_tc;
      if (rx_state == DATA && rx_end) begin
        rx_shift <= {rx_in, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
      if (rx_done) rx_buf <= rx_shift;
      rda  <= rx_done || (rda && !(rd && bus.ioaddr == 2'd0));
      ovr  <= (rx_done && rda && !(rd && bus.ioaddr == 2'd0)) || (ovr && !(rd && bus.ioaddr == 2'd1));
      ferr <= rx_bad || (ferr && !(rd && bus.ioaddr == 2'd1));
    end
endmodule
